// File: rtl/tl_pkg.sv
// Shared TileLink opcode, beat-count and error-index definitions for the
// in-flight tracker.
package tl_pkg;

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] ArithmeticData = 3'd2;
    localparam logic [2:0] LogicalData    = 3'd3;
    localparam logic [2:0] Get            = 3'd4;

    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;
    localparam logic [2:0] GrantData      = 3'd5;

    localparam int ERR_W            = 5;
    localparam int ERR_SRC_REUSE    = 0;
    localparam int ERR_D_UNEXPECTED = 1;
    localparam int ERR_A_BURST_CHG  = 2;
    localparam int ERR_D_BURST_CHG  = 3;
    localparam int ERR_TIMEOUT      = 4;

    function automatic logic a_has_data(input logic [2:0] opcode);
        case (opcode)
            PutFullData, PutPartialData, ArithmeticData, LogicalData: return 1'b1;
            Get:     return 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic d_has_data(input logic [2:0] opcode);
        case (opcode)
            AccessAckData, GrantData: return 1'b1;
            AccessAck: return 1'b0;
            default:   return 1'b0;
        endcase
    endfunction

    // Sub-bus-width transfers still occupy one beat.
    function automatic logic [31:0] num_beats(input logic [31:0] size, input logic has_data,
                                              input int unsigned beat_log2);
        logic [31:0] b;
        b = (32'd1 << size) >> beat_log2;
        if (!has_data || b == '0) b = 32'd1;
        return b;
    endfunction

endpackage

// File: rtl/tl_inflight_tracker_if.sv
// A/D channel signal bundle observed by the in-flight tracker.
interface tl_inflight_tracker_if #(
    parameter int SOURCE_W = 3,
    parameter int SIZE_W   = 3
);
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [SIZE_W-1:0]   a_size;
    logic [SOURCE_W-1:0] a_source;
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [SIZE_W-1:0]   d_size;
    logic [SOURCE_W-1:0] d_source;

    modport master (
        output a_valid, a_opcode, a_size, a_source, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source
    );

    modport monitor (
        input a_valid, a_ready, a_opcode, a_size, a_source,
              d_valid, d_ready, d_opcode, d_size, d_source
    );
endinterface

// File: rtl/tl_beat_counter.sv
// Per-channel beat counter: remaining beats of the current message, 0 = idle/first.
module tl_beat_counter
    import tl_pkg::*;
#(
    parameter int SIZE_W    = 3,
    parameter int BEAT_LOG2 = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fire,
    input  logic              has_data,
    input  logic [SIZE_W-1:0] size,
    output logic              first,
    output logic              last
);
    localparam int CNT_W = 2 ** SIZE_W;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] beats;

    assign beats = CNT_W'(num_beats(32'(size), has_data, BEAT_LOG2));
    assign first = (cnt == '0);
    assign last  = (cnt == CNT_W'(1)) | (first & (beats == CNT_W'(1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (fire) begin
            cnt <= first ? beats - 1'b1 : cnt - 1'b1;
        end
    end
endmodule

// File: rtl/tl_inflight_tracker.sv
// Passive TileLink A/D tracker: beat first/last, in-flight source bitmap,
// watchdog and sticky protocol-error flags.
module tl_inflight_tracker
    import tl_pkg::*;
#(
    parameter int SOURCE_W  = 3,
    parameter int SIZE_W    = 3,
    parameter int BEAT_LOG2 = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clock,
    input  logic                   reset_n,
    tl_inflight_tracker_if.monitor tl,
    input  logic                   err_clear,
    output logic                   a_first,
    output logic                   a_last,
    output logic                   d_first,
    output logic                   d_last,
    output logic [2**SOURCE_W-1:0] inflight,
    output logic [SOURCE_W:0]      inflight_cnt,
    output logic [ERR_W-1:0]       err,
    output logic                   err_any
);
    localparam int NSRC = 2 ** SOURCE_W;
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic a_fire, d_fire, a_set, d_open, d_clr;

    assign a_fire = tl.a_valid & tl.a_ready;
    assign d_fire = tl.d_valid & tl.d_ready;
    assign a_set  = a_fire & a_first;
    assign d_open = d_fire & d_first;
    assign d_clr  = d_fire & d_last;

    tl_beat_counter #(.SIZE_W(SIZE_W), .BEAT_LOG2(BEAT_LOG2)) u_a_beats (
        .clock    (clock),
        .reset_n  (reset_n),
        .fire     (a_fire),
        .has_data (a_has_data(tl.a_opcode)),
        .size     (tl.a_size),
        .first    (a_first),
        .last     (a_last)
    );

    tl_beat_counter #(.SIZE_W(SIZE_W), .BEAT_LOG2(BEAT_LOG2)) u_d_beats (
        .clock    (clock),
        .reset_n  (reset_n),
        .fire     (d_fire),
        .has_data (d_has_data(tl.d_opcode)),
        .size     (tl.d_size),
        .first    (d_first),
        .last     (d_last)
    );

    logic [2:0]          a_op_q, d_op_q;
    logic [SIZE_W-1:0]   a_size_q, d_size_q;
    logic [SOURCE_W-1:0] a_src_q, d_src_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_op_q   <= '0;
            a_size_q <= '0;
            a_src_q  <= '0;
            d_op_q   <= '0;
            d_size_q <= '0;
            d_src_q  <= '0;
        end else begin
            if (a_set) begin
                a_op_q   <= tl.a_opcode;
                a_size_q <= tl.a_size;
                a_src_q  <= tl.a_source;
            end
            if (d_open) begin
                d_op_q   <= tl.d_opcode;
                d_size_q <= tl.d_size;
                d_src_q  <= tl.d_source;
            end
        end
    end

    logic [WD_W-1:0] wd, wd_inc;
    logic            timeout_hit;

    // Flag only on the transition into TIMEOUT so err_clear can re-arm it.
    always_comb begin
        if (d_fire || inflight_cnt == '0) wd_inc = '0;
        else if (wd == WD_MAX)            wd_inc = wd;
        else                              wd_inc = wd + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (wd != WD_MAX) && (wd_inc == WD_MAX);
    end

    logic [NSRC-1:0]     inflight_nxt;
    logic [SOURCE_W:0]   cnt_nxt;
    logic [ERR_W-1:0]    err_evt;
    logic [ERR_W-1:0]    err_nxt;

    // Clear before set: a same-cycle reuse of the retiring source keeps the bit.
    always_comb begin
        inflight_nxt = inflight;
        if (d_clr) inflight_nxt[tl.d_source] = 1'b0;
        if (a_set) inflight_nxt[tl.a_source] = 1'b1;

        err_evt = '0;
        err_evt[ERR_SRC_REUSE] = a_set &
            (inflight[tl.a_source] | (d_clr & (tl.d_source == tl.a_source)));
        err_evt[ERR_D_UNEXPECTED] = d_open & ~inflight[tl.d_source] &
            ~(a_set & (tl.a_source == tl.d_source));
        err_evt[ERR_A_BURST_CHG] = a_fire & ~a_first &
            ({tl.a_opcode, tl.a_size, tl.a_source} != {a_op_q, a_size_q, a_src_q});
        err_evt[ERR_D_BURST_CHG] = d_fire & ~d_first &
            ({tl.d_opcode, tl.d_size, tl.d_source} != {d_op_q, d_size_q, d_src_q});
        err_evt[ERR_TIMEOUT] = timeout_hit;

        err_nxt = (err_clear ? '0 : err) | err_evt;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            cnt_nxt = cnt_nxt + (SOURCE_W + 1)'(inflight_nxt[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight     <= '0;
            inflight_cnt <= '0;
            err          <= '0;
            err_any      <= 1'b0;
            wd           <= '0;
        end else begin
            inflight     <= inflight_nxt;
            inflight_cnt <= cnt_nxt;
            err          <= err_nxt;
            err_any      <= |err_nxt;
            wd           <= err_clear ? '0 : wd_inc;
        end
    end
endmodule

// File: tb/tb_tl_inflight_tracker.sv
// Bench for tl_inflight_tracker: directed vector table, watchdog/reset sequences
// and randomized traffic against a message-level reference model.
module tb_tl_inflight_tracker;
    localparam int SW = 3;
    localparam int ZW = 3;
    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       err_clear = 1'b0;
    logic       a_first, a_last, d_first, d_last;
    logic [7:0] inflight;
    logic [3:0] inflight_cnt;
    logic [4:0] err;
    logic       err_any;

    int n_checks = 0;
    int n_fail   = 0;

    tl_inflight_tracker_if #(.SOURCE_W(SW), .SIZE_W(ZW)) bus ();

    tl_inflight_tracker #(
        .SOURCE_W (SW),
        .SIZE_W   (ZW),
        .BEAT_LOG2(2),
        .TIMEOUT  (TO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tl           (bus),
        .err_clear    (err_clear),
        .a_first      (a_first),
        .a_last       (a_last),
        .d_first      (d_first),
        .d_last       (d_last),
        .inflight     (inflight),
        .inflight_cnt (inflight_cnt),
        .err          (err),
        .err_any      (err_any)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_a(input logic [1:0] h, input logic [2:0] op, input logic [2:0] sz, input logic [2:0] src);
        bus.a_valid = h[1]; bus.a_ready = h[0];
        bus.a_opcode = op; bus.a_size = sz; bus.a_source = src;
    endtask

    task automatic set_d(input logic [1:0] h, input logic [2:0] op, input logic [2:0] sz, input logic [2:0] src);
        bus.d_valid = h[1]; bus.d_ready = h[0];
        bus.d_opcode = op; bus.d_size = sz; bus.d_source = src;
    endtask

    typedef struct {
        logic [1:0] ah; logic [2:0] aop; logic [2:0] asz; logic [2:0] asrc;
        logic [1:0] dh; logic [2:0] dop; logic [2:0] dsz; logic [2:0] dsrc;
        logic       clr;
        logic [3:0] fl;   // {a_first,a_last,d_first,d_last} before the edge
        logic [7:0] infl; logic [3:0] cnt; logic [4:0] e;  // after the edge
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] ah, input logic [2:0] aop, input logic [2:0] asz, input logic [2:0] asrc,
                       input logic [1:0] dh, input logic [2:0] dop, input logic [2:0] dsz, input logic [2:0] dsrc,
                       input logic clr, input logic [3:0] fl, input logic [7:0] infl, input logic [3:0] cnt,
                       input logic [4:0] e);
        vec_t v;
        v.ah = ah; v.aop = aop; v.asz = asz; v.asrc = asrc;
        v.dh = dh; v.dop = dop; v.dsz = dsz; v.dsrc = dsrc;
        v.clr = clr; v.fl = fl; v.infl = infl; v.cnt = cnt; v.e = e;
        tbl.push_back(v);
    endtask

    // Reference model: message-level view (beat index within message, source set).
    int         a_idx, a_tot, d_idx, d_tot, m_wd;
    logic [2:0] a_lop, a_lsz, a_lsrc, d_lop, d_lsz, d_lsrc;
    logic [7:0] m_infl;
    logic [4:0] m_err;

    function automatic int beats_of(input bit has_data, input int size);
        int b;
        if (!has_data) return 1;
        b = (2 ** size) / 4;
        return (b < 1) ? 1 : b;
    endfunction

    function automatic bit a_data(input logic [2:0] op); return op <= 3'd3; endfunction
    function automatic bit d_data(input logic [2:0] op); return op == 3'd1 || op == 3'd5; endfunction

    function automatic bit m_a_last();
        if (a_idx == 0) return beats_of(a_data(bus.a_opcode), int'(bus.a_size)) == 1;
        return a_idx == a_tot - 1;
    endfunction

    function automatic bit m_d_last();
        if (d_idx == 0) return beats_of(d_data(bus.d_opcode), int'(bus.d_size)) == 1;
        return d_idx == d_tot - 1;
    endfunction

    task automatic model_reset();
        a_idx = 0; a_tot = 1; d_idx = 0; d_tot = 1; m_wd = 0;
        a_lop = '0; a_lsz = '0; a_lsrc = '0; d_lop = '0; d_lsz = '0; d_lsrc = '0;
        m_infl = '0; m_err = '0;
    endtask

    task automatic model_step();
        bit af, df, a_beg, a_end, d_beg, d_end;
        logic [4:0] ev;
        logic [7:0] nxt;
        int inc;
        af = bus.a_valid && bus.a_ready;
        df = bus.d_valid && bus.d_ready;
        a_beg = af && a_idx == 0; a_end = af && m_a_last();
        d_beg = df && d_idx == 0; d_end = df && m_d_last();
        ev = '0;
        if (af) begin
            if (a_idx == 0) begin
                a_tot = beats_of(a_data(bus.a_opcode), int'(bus.a_size));
                a_lop = bus.a_opcode; a_lsz = bus.a_size; a_lsrc = bus.a_source;
            end else if (bus.a_opcode != a_lop || bus.a_size != a_lsz || bus.a_source != a_lsrc) ev[2] = 1'b1;
            a_idx = a_end ? 0 : a_idx + 1;
        end
        if (df) begin
            if (d_idx == 0) begin
                d_tot = beats_of(d_data(bus.d_opcode), int'(bus.d_size));
                d_lop = bus.d_opcode; d_lsz = bus.d_size; d_lsrc = bus.d_source;
            end else if (bus.d_opcode != d_lop || bus.d_size != d_lsz || bus.d_source != d_lsrc) ev[3] = 1'b1;
            d_idx = d_end ? 0 : d_idx + 1;
        end
        nxt = m_infl;
        if (d_end) nxt[bus.d_source] = 1'b0;
        if (a_beg) begin
            if (m_infl[bus.a_source] || (d_end && bus.d_source == bus.a_source)) ev[0] = 1'b1;
            nxt[bus.a_source] = 1'b1;
        end
        if (d_beg && !m_infl[bus.d_source] && !(a_beg && bus.a_source == bus.d_source)) ev[1] = 1'b1;
        inc = (df || m_infl == '0) ? 0 : ((m_wd < TO) ? m_wd + 1 : TO);
        if (m_wd < TO && inc == TO) ev[4] = 1'b1;
        m_wd = err_clear ? 0 : inc;
        m_err = (err_clear ? 5'b0 : m_err) | ev;
        m_infl = nxt;
    endtask

    initial begin
        set_a(2'b00, 3'd4, 3'd0, 3'd0);
        set_d(2'b00, 3'd0, 3'd0, 3'd0);
        #3;
        chk("reset a_first", a_first, 1);
        chk("reset d_first", d_first, 1);
        chk("reset inflight", inflight, 0);
        chk("reset cnt", inflight_cnt, 0);
        chk("reset err", err, 0);
        chk("reset err_any", err_any, 0);
        @(posedge clock); #1 reset_n = 1'b1;

        // ah, aop,asz,asrc, dh, dop,dsz,dsrc, clr, fl, infl, cnt, err
        add(2'b11,4,2,3, 2'b00,0,0,0, 0, 4'b1111, 8'h08, 1, 5'h00); // Get src3
        add(2'b00,4,0,0, 2'b11,1,2,3, 0, 4'b1111, 8'h00, 0, 5'h00); // AccessAckData src3
        add(2'b11,0,4,0, 2'b00,0,0,0, 0, 4'b1011, 8'h01, 1, 5'h00); // Put 4 beats, beat1
        add(2'b01,0,4,0, 2'b00,0,0,0, 0, 4'b0011, 8'h01, 1, 5'h00); // valid gap
        add(2'b11,0,4,0, 2'b00,0,0,0, 0, 4'b0011, 8'h01, 1, 5'h00); // beat2
        add(2'b10,0,4,0, 2'b00,0,0,0, 0, 4'b0011, 8'h01, 1, 5'h00); // ready gap
        add(2'b11,0,4,0, 2'b00,0,0,0, 0, 4'b0011, 8'h01, 1, 5'h00); // beat3
        add(2'b11,0,4,0, 2'b00,0,0,0, 0, 4'b0111, 8'h01, 1, 5'h00); // beat4 last
        add(2'b00,4,0,0, 2'b11,0,4,0, 0, 4'b1111, 8'h00, 0, 5'h00); // AccessAck src0
        add(2'b11,4,2,5, 2'b00,0,0,0, 0, 4'b1111, 8'h20, 1, 5'h00); // Get src5
        add(2'b11,4,2,5, 2'b00,0,0,0, 0, 4'b1111, 8'h20, 1, 5'h01); // Get src5 again
        add(2'b00,4,0,0, 2'b11,0,2,5, 1, 4'b1111, 8'h00, 0, 5'h00); // ack + clear
        add(2'b00,4,0,0, 2'b11,0,2,2, 0, 4'b1111, 8'h00, 0, 5'h02); // unexpected ack
        add(2'b00,4,0,0, 2'b00,0,0,0, 1, 4'b1111, 8'h00, 0, 5'h00); // clear
        add(2'b11,0,4,1, 2'b00,0,0,0, 0, 4'b1011, 8'h02, 1, 5'h00); // Put src1 beat1
        add(2'b11,0,4,4, 2'b00,0,0,0, 0, 4'b0011, 8'h02, 1, 5'h04); // beat2 source changed
        add(2'b11,0,4,1, 2'b00,0,0,0, 0, 4'b0011, 8'h02, 1, 5'h04);
        add(2'b11,0,4,1, 2'b00,0,0,0, 0, 4'b0111, 8'h02, 1, 5'h04);
        add(2'b00,4,0,0, 2'b11,0,0,1, 1, 4'b1111, 8'h00, 0, 5'h00);
        add(2'b11,4,4,6, 2'b00,0,0,0, 0, 4'b1111, 8'h40, 1, 5'h00); // Get src6
        add(2'b00,4,0,0, 2'b11,1,3,6, 0, 4'b1110, 8'h40, 1, 5'h00); // 2-beat data, beat1
        add(2'b11,4,2,1, 2'b11,1,3,6, 0, 4'b1101, 8'h02, 1, 5'h00); // A src1 + D last src6
        add(2'b00,4,0,0, 2'b11,0,2,1, 0, 4'b1111, 8'h00, 0, 5'h00);
        add(2'b11,4,2,2, 2'b00,0,0,0, 0, 4'b1111, 8'h04, 1, 5'h00);
        add(2'b11,4,2,2, 2'b11,0,2,2, 0, 4'b1111, 8'h04, 1, 5'h01); // reuse while retiring
        add(2'b00,4,0,0, 2'b11,0,2,2, 1, 4'b1111, 8'h00, 0, 5'h00);
        add(2'b11,4,2,7, 2'b11,0,2,7, 0, 4'b1111, 8'h80, 1, 5'h01); // same-cycle A/D src7
        add(2'b00,4,0,0, 2'b11,0,2,7, 1, 4'b1111, 8'h00, 0, 5'h00);
        add(2'b11,4,2,0, 2'b00,0,0,0, 0, 4'b1111, 8'h01, 1, 5'h00);
        add(2'b00,4,0,0, 2'b11,1,3,0, 0, 4'b1110, 8'h01, 1, 5'h00);
        add(2'b00,4,0,0, 2'b11,1,3,3, 0, 4'b1101, 8'h01, 1, 5'h08); // D source changed
        add(2'b00,4,0,0, 2'b11,0,2,0, 1, 4'b1111, 8'h00, 0, 5'h00);

        foreach (tbl[i]) begin
            set_a(tbl[i].ah, tbl[i].aop, tbl[i].asz, tbl[i].asrc);
            set_d(tbl[i].dh, tbl[i].dop, tbl[i].dsz, tbl[i].dsrc);
            err_clear = tbl[i].clr;
            @(negedge clock);
            chk($sformatf("v%0d first/last", i), {a_first, a_last, d_first, d_last}, tbl[i].fl);
            @(posedge clock); #1;
            chk($sformatf("v%0d inflight", i), inflight, tbl[i].infl);
            chk($sformatf("v%0d cnt", i), inflight_cnt, tbl[i].cnt);
            chk($sformatf("v%0d err", i), err, tbl[i].e);
            chk($sformatf("v%0d err_any", i), err_any, |tbl[i].e);
        end

        // Watchdog: one Get outstanding, err[4] on the 16th idle cycle.
        err_clear = 1'b0;
        set_d(2'b00, 3'd0, 3'd0, 3'd0);
        set_a(2'b11, 3'd4, 3'd2, 3'd0);
        @(posedge clock); #1;
        set_a(2'b00, 3'd4, 3'd0, 3'd0);
        for (int c = 1; c < TO; c++) begin
            @(posedge clock); #1;
            chk($sformatf("wd idle %0d", c), err, 0);
        end
        @(posedge clock); #1;
        chk("wd timeout err", err, 5'h10);
        chk("wd timeout err_any", err_any, 1);

        // Reset mid-burst is immediate.
        set_a(2'b11, 3'd0, 3'd4, 3'd3);
        @(posedge clock); #1;
        chk("mid-burst a_first", a_first, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async a_first", a_first, 1);
        chk("async d_first", d_first, 1);
        chk("async inflight", inflight, 0);
        chk("async cnt", inflight_cnt, 0);
        chk("async err", err, 0);
        chk("async err_any", err_any, 0);
        set_a(2'b00, 3'd4, 3'd0, 3'd0);
        @(posedge clock); #1 reset_n = 1'b1;

        // Randomized traffic against the reference model.
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            if (a_idx == 0 || $urandom_range(0, 9) == 0)
                set_a({1'b0, 1'b0}, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 7)));
            bus.a_valid = ($urandom_range(0, 3) != 0);
            bus.a_ready = ($urandom_range(0, 3) != 0);
            if (d_idx == 0 || $urandom_range(0, 9) == 0)
                set_d({1'b0, 1'b0}, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 7)));
            bus.d_valid = ($urandom_range(0, 2) != 0);
            bus.d_ready = ($urandom_range(0, 4) != 0);
            err_clear = ($urandom_range(0, 15) == 0);
            @(negedge clock);
            chk("rnd a_first", a_first, 32'(a_idx == 0));
            chk("rnd a_last", a_last, 32'(m_a_last()));
            chk("rnd d_first", d_first, 32'(d_idx == 0));
            chk("rnd d_last", d_last, 32'(m_d_last()));
            model_step();
            @(posedge clock); #1;
            chk("rnd inflight", inflight, m_infl);
            chk("rnd cnt", inflight_cnt, $countones(m_infl));
            chk("rnd err", err, m_err);
            chk("rnd err_any", err_any, 32'(|m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
